// File: rtl/seven_seg_pkg.sv
// Shared segment encoding for the seven-segment scan driver.
// Segment vectors are {a,b,c,d,e,f,g} with a in bit 6, active-high before any pin inversion.
package seven_seg_pkg;

   localparam int unsigned SEG_W = 7;

   localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

   localparam logic [SEG_W-1:0] SEG_TABLE [16] = '{
      7'b1111110,  // 0
      7'b0110000,  // 1
      7'b1101101,  // 2
      7'b1111001,  // 3
      7'b0110011,  // 4
      7'b1011011,  // 5
      7'b1011111,  // 6
      7'b1110000,  // 7
      7'b1111111,  // 8
      7'b1111011,  // 9
      7'b1110111,  // A
      7'b0011111,  // b
      7'b1001110,  // C
      7'b0111101,  // d
      7'b1001111,  // E
      7'b1000111   // F
   };

   // Without hex mode, nibbles above 9 have no glyph and are shown dark.
   function automatic logic [SEG_W-1:0] seg_decode(input logic [3:0] nibble,
                                                   input logic       hex_mode);
      logic [SEG_W-1:0] v_seg;
      v_seg = SEG_TABLE[nibble];
      if (!hex_mode && (nibble > 4'd9)) begin
         v_seg = SEG_BLANK;
      end
      return v_seg;
   endfunction

endpackage

// File: rtl/seven_seg_decode.sv
// Combinational nibble-to-segment decoder for the currently scanned digit.
module seven_seg_decode
   import seven_seg_pkg::*;
#(
   parameter bit HEX_MODE = 1'b1
) (
   input  logic [3:0]       i_nibble,
   output logic [SEG_W-1:0] o_seg_c
);

   always_comb begin
      o_seg_c = seg_decode(i_nibble, HEX_MODE);
   end

endmodule

// File: rtl/seven_segment_scan_driver.sv
// Time-multiplexed N-digit seven-segment driver with frame-synchronous double buffering,
// leading-zero suppression and optional active-low pin polarity.
module seven_segment_scan_driver
   import seven_seg_pkg::*;
#(
   parameter int unsigned NUM_DIGITS  = 4,
   parameter int unsigned PRESCALE    = 4,
   parameter bit          HEX_MODE    = 1'b1,
   parameter bit          LZ_SUPPRESS = 1'b1,
   parameter bit          ACTIVE_LOW  = 1'b0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    blank,
   output logic [SEG_W-1:0]        seg,
   output logic                    dp,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    frame_tick
);

   localparam int unsigned VAL_W = 4 * NUM_DIGITS;
   localparam int unsigned PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [SEG_W-1:0]      SEG_POL = {SEG_W{ACTIVE_LOW}};
   localparam logic [NUM_DIGITS-1:0] AN_POL  = {NUM_DIGITS{ACTIVE_LOW}};

   logic [PS_W-1:0]       r_presc;
   logic [IDX_W-1:0]      r_idx;
   logic [VAL_W-1:0]      r_disp_val;
   logic [NUM_DIGITS-1:0] r_disp_dp;
   logic [VAL_W-1:0]      r_pend_val;
   logic [NUM_DIGITS-1:0] r_pend_dp;
   logic                  r_pend_valid;

   logic                  w_tick;
   logic                  w_wrap;
   logic [3:0]            w_nibble;
   logic                  w_dp_cur;
   logic                  w_upper_zero;
   logic                  w_lz_zero;
   logic [SEG_W-1:0]      w_seg_dec;
   logic [SEG_W-1:0]      w_seg_nxt;
   logic [NUM_DIGITS-1:0] w_an_nxt;

   // Dwell tick and frame boundary
   always_comb begin
      w_tick = (r_presc == PS_W'(PRESCALE - 1));
      w_wrap = w_tick && (r_idx == IDX_W'(NUM_DIGITS - 1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_presc <= '0;
      end else if (w_tick) begin
         r_presc <= '0;
      end else begin
         r_presc <= r_presc + PS_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx <= '0;
      end else if (w_tick) begin
         r_idx <= w_wrap ? '0 : r_idx + IDX_W'(1);
      end
   end

   // Pending/display buffers: a load on the wrap cycle bypasses straight to display
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pend_val   <= '0;
         r_pend_dp    <= '0;
         r_pend_valid <= 1'b0;
         r_disp_val   <= '0;
         r_disp_dp    <= '0;
      end else begin
         if (load) begin
            r_pend_val <= value;
            r_pend_dp  <= dp_in;
         end
         if (w_wrap) begin
            r_pend_valid <= 1'b0;
            if (load) begin
               r_disp_val <= value;
               r_disp_dp  <= dp_in;
            end else if (r_pend_valid) begin
               r_disp_val <= r_pend_val;
               r_disp_dp  <= r_pend_dp;
            end
         end else if (load) begin
            r_pend_valid <= 1'b1;
         end
      end
   end

   // Current-digit select; w_upper_zero accumulates "this and all higher nibbles are 0"
   always_comb begin
      w_nibble     = 4'h0;
      w_dp_cur     = 1'b0;
      w_lz_zero    = 1'b0;
      w_upper_zero = 1'b1;
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
         w_upper_zero = w_upper_zero && (r_disp_val[4*k +: 4] == 4'h0);
         if (IDX_W'(k) == r_idx) begin
            w_nibble  = r_disp_val[4*k +: 4];
            w_dp_cur  = r_disp_dp[k];
            w_lz_zero = w_upper_zero && (k != 0);
         end
      end
   end

   seven_seg_decode #(
      .HEX_MODE (HEX_MODE)
   ) u_decode (
      .i_nibble (w_nibble),
      .o_seg_c  (w_seg_dec)
   );

   always_comb begin
      w_seg_nxt = w_seg_dec;
      if (LZ_SUPPRESS && w_lz_zero) begin
         w_seg_nxt = SEG_BLANK;
      end
      w_an_nxt = '0;
      if (!blank) begin
         w_an_nxt = NUM_DIGITS'(1) << r_idx;
      end
   end

   // Registered pins; polarity applied last so reset lands on the inactive level
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg        <= SEG_POL;
         dp         <= ACTIVE_LOW;
         an         <= AN_POL;
         frame_tick <= 1'b0;
      end else begin
         seg        <= w_seg_nxt ^ SEG_POL;
         dp         <= w_dp_cur ^ ACTIVE_LOW;
         an         <= w_an_nxt ^ AN_POL;
         frame_tick <= w_wrap;
      end
   end

endmodule

// File: tb/tb_seven_segment_scan_driver.sv
// Directed bench: default driver, a BCD-only variant and an active-low single-cycle-dwell variant.
module tb_seven_segment_scan_driver;

   logic        clk      = 1'b0;
   logic        clk_en   = 1'b0;
   logic        rst_n    = 1'b1;
   logic        rst_al_n = 1'b1;
   logic        load     = 1'b0;
   logic        blank    = 1'b0;
   logic [15:0] value    = '0;
   logic [3:0]  dp_in    = '0;

   logic [6:0] seg0, seg1, seg2;
   logic       dp0, dp1, dp2;
   logic [3:0] an0, an1, an2;
   logic       ft0, ft1, ft2;

   int n_cmp  = 0;
   int n_err  = 0;
   int ecount = 0;

   always #5 if (clk_en) clk = ~clk;

   seven_segment_scan_driver #(
      .NUM_DIGITS(4), .PRESCALE(4), .HEX_MODE(1'b1), .LZ_SUPPRESS(1'b1), .ACTIVE_LOW(1'b0)
   ) dut0 (
      .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp_in(dp_in), .blank(blank),
      .seg(seg0), .dp(dp0), .an(an0), .frame_tick(ft0)
   );

   seven_segment_scan_driver #(
      .NUM_DIGITS(4), .PRESCALE(4), .HEX_MODE(1'b0), .LZ_SUPPRESS(1'b1), .ACTIVE_LOW(1'b0)
   ) dut1 (
      .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp_in(dp_in), .blank(blank),
      .seg(seg1), .dp(dp1), .an(an1), .frame_tick(ft1)
   );

   seven_segment_scan_driver #(
      .NUM_DIGITS(4), .PRESCALE(1), .HEX_MODE(1'b1), .LZ_SUPPRESS(1'b1), .ACTIVE_LOW(1'b1)
   ) dut2 (
      .clk(clk), .rst_n(rst_al_n), .load(load), .value(value), .dp_in(dp_in), .blank(blank),
      .seg(seg2), .dp(dp2), .an(an2), .frame_tick(ft2)
   );

   task automatic step();
      @(posedge clk);
      #1;
      ecount++;
   endtask

   task automatic run_to(input int target);
      while (ecount < target) step();
   endtask

   task automatic do_load(input logic [15:0] v, input logic [3:0] d);
      load = 1'b1; value = v; dp_in = d;
      step();
      load = 1'b0;
   endtask

   task automatic test_reset();
      logic [3:0] exp_an;
      logic       exp_ft;
      #2;
      rst_n = 1'b0; rst_al_n = 1'b0;
      #10;
      n_cmp++; if (seg0 !== 7'b0000000) begin n_err++; $display("FAIL rst_seg: got %b want %b", seg0, 7'b0000000); end
      n_cmp++; if (dp0 !== 1'b0) begin n_err++; $display("FAIL rst_dp: got %b want 0", dp0); end
      n_cmp++; if (an0 !== 4'b0000) begin n_err++; $display("FAIL rst_an: got %b want 0000", an0); end
      n_cmp++; if (ft0 !== 1'b0) begin n_err++; $display("FAIL rst_ft: got %b want 0", ft0); end
      n_cmp++; if (seg2 !== 7'b1111111) begin n_err++; $display("FAIL rst_al_seg: got %b want 1111111", seg2); end
      n_cmp++; if (an2 !== 4'b1111) begin n_err++; $display("FAIL rst_al_an: got %b want 1111", an2); end
      rst_n = 1'b1; rst_al_n = 1'b1;
      #3;
      clk_en = 1'b1;
      step();
      n_cmp++; if (an0 !== 4'b0001) begin n_err++; $display("FAIL rst_first_an: got %b want 0001", an0); end
      for (int e = 2; e <= 33; e++) begin
         step();
         exp_an = 4'b0001 << (((e - 1) / 4) % 4);
         exp_ft = ((e % 16) == 0);
         n_cmp++; if (an0 !== exp_an) begin n_err++; $display("FAIL scan_an e=%0d: got %b want %b", e, an0, exp_an); end
         n_cmp++; if (ft0 !== exp_ft) begin n_err++; $display("FAIL frame_tick e=%0d: got %b want %b", e, ft0, exp_ft); end
      end
   endtask

   task automatic test_load_midframe();
      logic [6:0] exp_seg [4];
      logic       exp_dp  [4];
      exp_seg = '{7'b0110011, 7'b1111001, 7'b1101101, 7'b0110000};
      exp_dp  = '{1'b0, 1'b0, 1'b1, 1'b0};
      run_to(33);
      do_load(16'h1234, 4'b0100);
      run_to(37);
      n_cmp++; if (seg0 !== 7'b0000000) begin n_err++; $display("FAIL old_disp_d1: got %b want 0000000", seg0); end
      run_to(45);
      n_cmp++; if (seg0 !== 7'b0000000) begin n_err++; $display("FAIL old_disp_d3: got %b want 0000000", seg0); end
      for (int d = 0; d < 4; d++) begin
         run_to(49 + 4*d);
         n_cmp++; if (seg0 !== exp_seg[d]) begin n_err++; $display("FAIL new_seg d%0d: got %b want %b", d, seg0, exp_seg[d]); end
         n_cmp++; if (dp0 !== exp_dp[d]) begin n_err++; $display("FAIL new_dp d%0d: got %b want %b", d, dp0, exp_dp[d]); end
         n_cmp++; if (an0 !== (4'b0001 << d)) begin n_err++; $display("FAIL new_an d%0d: got %b want %b", d, an0, 4'b0001 << d); end
      end
   endtask

   task automatic test_back_to_back();
      run_to(66);
      do_load(16'h1111, 4'b0000);
      run_to(70);
      do_load(16'h2222, 4'b0000);
      run_to(77);
      n_cmp++; if (seg0 !== 7'b0110000) begin n_err++; $display("FAIL b2b_hold: got %b want 0110000", seg0); end
      run_to(81);
      n_cmp++; if (seg0 !== 7'b1101101) begin n_err++; $display("FAIL b2b_last_wins: got %b want 1101101", seg0); end
      run_to(85);
      do_load(16'h9999, 4'b0000);
      run_to(89);
      n_cmp++; if (seg0 !== 7'b1101101) begin n_err++; $display("FAIL b2b_no_tear: got %b want 1101101", seg0); end
      n_cmp++; if (dp0 !== 1'b0) begin n_err++; $display("FAIL b2b_dp: got %b want 0", dp0); end
      run_to(95);
      do_load(16'h5678, 4'b0001);
      n_cmp++; if (seg0 !== 7'b1101101) begin n_err++; $display("FAIL wrap_load_edge: got %b want 1101101", seg0); end
      run_to(97);
      n_cmp++; if (seg0 !== 7'b1111111) begin n_err++; $display("FAIL bypass_seg: got %b want 1111111", seg0); end
      n_cmp++; if (dp0 !== 1'b1) begin n_err++; $display("FAIL bypass_dp: got %b want 1", dp0); end
      run_to(109);
      n_cmp++; if (seg0 !== 7'b1011011) begin n_err++; $display("FAIL bypass_d3: got %b want 1011011", seg0); end
      run_to(113);
      n_cmp++; if (seg0 !== 7'b1111111) begin n_err++; $display("FAIL bypass_stays: got %b want 1111111", seg0); end
   endtask

   task automatic test_lz_suppress();
      run_to(113);
      do_load(16'h0005, 4'b0000);
      run_to(129);
      n_cmp++; if (seg0 !== 7'b1011011) begin n_err++; $display("FAIL lz_d0: got %b want 1011011", seg0); end
      n_cmp++; if (an0 !== 4'b0001) begin n_err++; $display("FAIL lz_an0: got %b want 0001", an0); end
      for (int d = 1; d < 4; d++) begin
         run_to(129 + 4*d);
         n_cmp++; if (seg0 !== 7'b0000000) begin n_err++; $display("FAIL lz_blank d%0d: got %b want 0000000", d, seg0); end
         n_cmp++; if (an0 !== (4'b0001 << d)) begin n_err++; $display("FAIL lz_an d%0d: got %b want %b", d, an0, 4'b0001 << d); end
      end
      do_load(16'h0000, 4'b0000);
      run_to(145);
      n_cmp++; if (seg0 !== 7'b1111110) begin n_err++; $display("FAIL lz_zero_d0: got %b want 1111110", seg0); end
      run_to(149);
      n_cmp++; if (seg0 !== 7'b0000000) begin n_err++; $display("FAIL lz_zero_d1: got %b want 0000000", seg0); end
      do_load(16'h0105, 4'b0000);
      run_to(165);
      n_cmp++; if (seg0 !== 7'b1111110) begin n_err++; $display("FAIL lz_inner_zero: got %b want 1111110", seg0); end
      run_to(169);
      n_cmp++; if (seg0 !== 7'b0110000) begin n_err++; $display("FAIL lz_d2: got %b want 0110000", seg0); end
      run_to(173);
      n_cmp++; if (seg0 !== 7'b0000000) begin n_err++; $display("FAIL lz_d3: got %b want 0000000", seg0); end
   endtask

   task automatic test_hex_and_blank();
      run_to(173);
      do_load(16'h00BA, 4'b0000);
      run_to(177);
      n_cmp++; if (seg0 !== 7'b1110111) begin n_err++; $display("FAIL hex_A: got %b want 1110111", seg0); end
      n_cmp++; if (seg1 !== 7'b0000000) begin n_err++; $display("FAIL bcd_A: got %b want 0000000", seg1); end
      n_cmp++; if (an1 !== 4'b0001) begin n_err++; $display("FAIL bcd_an: got %b want 0001", an1); end
      run_to(181);
      n_cmp++; if (seg0 !== 7'b0011111) begin n_err++; $display("FAIL hex_b: got %b want 0011111", seg0); end
      n_cmp++; if (seg1 !== 7'b0000000) begin n_err++; $display("FAIL bcd_b: got %b want 0000000", seg1); end
      blank = 1'b1;
      step();
      n_cmp++; if (an0 !== 4'b0000) begin n_err++; $display("FAIL blank_an: got %b want 0000", an0); end
      run_to(192);
      n_cmp++; if (an0 !== 4'b0000) begin n_err++; $display("FAIL blank_hold: got %b want 0000", an0); end
      n_cmp++; if (ft0 !== 1'b1) begin n_err++; $display("FAIL blank_ft: got %b want 1", ft0); end
      blank = 1'b0;
      step();
      n_cmp++; if (an0 !== 4'b0001) begin n_err++; $display("FAIL unblank_an: got %b want 0001", an0); end
   endtask

   task automatic test_active_low();
      logic [3:0] exp_an [4];
      exp_an = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      step();
      step();
      rst_al_n = 1'b0;
      #1;
      n_cmp++; if (seg2 !== 7'b1111111) begin n_err++; $display("FAIL al_rst_seg: got %b want 1111111", seg2); end
      n_cmp++; if (dp2 !== 1'b1) begin n_err++; $display("FAIL al_rst_dp: got %b want 1", dp2); end
      n_cmp++; if (an2 !== 4'b1111) begin n_err++; $display("FAIL al_rst_an: got %b want 1111", an2); end
      #1;
      rst_al_n = 1'b1;
      for (int d = 0; d < 4; d++) begin
         step();
         n_cmp++; if (an2 !== exp_an[d]) begin n_err++; $display("FAIL al_an step%0d: got %b want %b", d, an2, exp_an[d]); end
         n_cmp++; if (ft2 !== (d == 3)) begin n_err++; $display("FAIL al_ft step%0d: got %b want %b", d, ft2, (d == 3)); end
         if (d == 0) begin
            n_cmp++; if (seg2 !== 7'b0000001) begin n_err++; $display("FAIL al_seg_d0: got %b want 0000001", seg2); end
            n_cmp++; if (dp2 !== 1'b1) begin n_err++; $display("FAIL al_dp_d0: got %b want 1", dp2); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_load_midframe();
      test_back_to_back();
      test_lz_suppress();
      test_hex_and_blank();
      test_active_low();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
